// File: rtl/prog_loader_if.sv
// Loader/CPU-fetch bundle for prog_loader. The loader side drives beats and the
// fetch address; the slave side (prog_loader) returns ready, fetch data, run and count.
interface prog_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_restart;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_run;
  logic [ADDR_W:0]   ld_count;

  modport master (
    output ld_valid, ld_data, ld_last, ld_restart, cpu_addr,
    input  ld_ready, cpu_data, cpu_run, ld_count
  );

  modport slave (
    input  ld_valid, ld_data, ld_last, ld_restart, cpu_addr,
    output ld_ready, cpu_data, cpu_run, ld_count
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: streams words into a small program memory, then releases the
// CPU. Unwritten words read as NOP_WORD; a restart or reset discards the program.
module prog_loader #(
  parameter int                 ADDR_W   = 4,
  parameter int                 DATA_W   = 8,
  parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
  input  logic          clk,
  input  logic          n_reset,
  prog_loader_if.slave  bus
);

  localparam int                DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W:0]     cnt;
  logic [DEPTH-1:0]    vbits;
  logic                run_q;
  logic                ready;
  logic                accept;
  logic                last_beat;
  logic [DATA_W-1:0]   mem [DEPTH];

  // State register
  always_ff @(posedge clk) begin
    if (n_reset) begin
      state <= S_LOAD;
      run_q <= 1'b0;
    end else begin
      state <= state_nxt;
      run_q <= (state_nxt == S_RUN);
    end
  end

  // Next-state logic: restart dominates, otherwise the final beat starts RUN
  always_comb begin
    state_nxt = state;
    if (bus.ld_restart) begin
      state_nxt = S_LOAD;
    end else if (last_beat) begin
      state_nxt = S_RUN;
    end
  end

  // Output / handshake logic; ready is held low while reset is asserted
  always_comb begin
    ready     = 1'b0;
    accept    = 1'b0;
    last_beat = 1'b0;
    if (!n_reset && (state == S_LOAD) && !bus.ld_restart) begin
      ready = 1'b1;
    end
    accept = ready && bus.ld_valid;
    if (accept && (bus.ld_last || (wr_ptr == PTR_MAX))) begin
      last_beat = 1'b1;
    end
  end

  // Write pointer, count and per-word valid bits; the pointer saturates so it never wraps
  always_ff @(posedge clk) begin
    if (n_reset || bus.ld_restart) begin
      wr_ptr <= '0;
      cnt    <= '0;
      vbits  <= '0;
    end else if (accept) begin
      vbits[wr_ptr] <= 1'b1;
      cnt           <= cnt + 1'b1;
      if (wr_ptr != PTR_MAX) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  // Storage is not reset; the valid bits alone decide what the CPU sees
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= bus.ld_data;
    end
  end

  assign bus.ld_ready = ready;
  assign bus.cpu_run  = run_q;
  assign bus.ld_count = cnt;
  assign bus.cpu_data = vbits[bus.cpu_addr] ? mem[bus.cpu_addr] : NOP_WORD;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a reference model tracks load state and
// a scoreboard queue holds accepted words until they are read back over cpu_addr.
module tb_prog_loader;

  localparam int         ADDR_W = 4;
  localparam int         DATA_W = 8;
  localparam int         DEPTH  = 16;
  localparam logic [7:0] NOP    = 8'h00;

  logic clk = 1'b0;
  logic n_reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOP_WORD(NOP)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model
  logic             m_run;
  logic [3:0]       m_ptr;
  int               m_cnt;
  logic [7:0]       m_mem [DEPTH];
  logic [DEPTH-1:0] m_vld;
  logic [11:0]      sb_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_run = 1'b0;
    m_ptr = '0;
    m_cnt = 0;
    m_vld = '0;
    sb_q.delete();
  endtask

  // One clock with the currently driven inputs; called at posedge+1
  task automatic tick();
    logic       exp_rdy;
    logic [7:0] exp_d;
    #1;
    exp_rdy = !n_reset && !bus.ld_restart && !m_run;
    chk("ld_ready", bus.ld_ready, exp_rdy);
    exp_d = m_vld[bus.cpu_addr] ? m_mem[bus.cpu_addr] : NOP;
    chk("cpu_data_pre_edge", bus.cpu_data, exp_d);
    if (n_reset || bus.ld_restart) begin
      model_clear();
    end else if (exp_rdy && bus.ld_valid) begin
      m_mem[m_ptr] = bus.ld_data;
      m_vld[m_ptr] = 1'b1;
      sb_q.push_back({m_ptr, bus.ld_data});
      if (bus.ld_last || m_ptr == 4'd15) m_run = 1'b1;
      if (m_ptr != 4'd15) m_ptr = m_ptr + 4'd1;
      m_cnt++;
    end
    @(posedge clk);
    #1;
    chk("cpu_run", bus.cpu_run, m_run);
    chk("ld_count", bus.ld_count, m_cnt);
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    bus.ld_last  = l;
    bus.cpu_addr = m_ptr;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic idle();
    bus.ld_valid = 1'b0;
    tick();
  endtask

  task automatic restart();
    bus.ld_restart = 1'b1;
    tick();
    bus.ld_restart = 1'b0;
  endtask

  // Drain the scoreboard against cpu_data, then confirm every unwritten word reads NOP
  task automatic check_mem(input string tag);
    logic [11:0] e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      @(negedge clk);
      bus.cpu_addr = e[11:8];
      #1;
      chk({tag, "_word"}, bus.cpu_data, e[7:0]);
    end
    for (int a = 0; a < DEPTH; a++) begin
      if (!m_vld[a]) begin
        @(negedge clk);
        bus.cpu_addr = 4'(a);
        #1;
        chk({tag, "_nop"}, bus.cpu_data, NOP);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_reset        = 1'b1;
    bus.ld_valid   = 1'b1;
    bus.ld_data    = 8'h99;
    bus.ld_last    = 1'b0;
    bus.ld_restart = 1'b0;
    bus.cpu_addr   = '0;
    model_clear();
    @(posedge clk);
    #1;
    // Reset with a beat pending: nothing accepted, ready stays low
    tick();
    tick();
    n_reset      = 1'b0;
    bus.ld_valid = 1'b0;
    check_mem("reset");

    // Three-word program ending on ld_last
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    beat(8'h33, 1'b1);
    chk("run_after_3", bus.cpu_run, 1'b1);
    check_mem("load3");

    // Full 16-word fill without ld_last, then an ignored 17th beat
    restart();
    for (int i = 0; i < DEPTH; i++) beat(8'(8'h40 + i), 1'b0);
    chk("count_full", bus.ld_count, 5'd16);
    beat(8'hEE, 1'b1);
    check_mem("full");

    // Valid gaps: 1,0,0,1
    restart();
    beat(8'h71, 1'b0);
    idle();
    idle();
    beat(8'h72, 1'b0);
    chk("count_gaps", bus.ld_count, 5'd2);
    check_mem("gaps");

    // Restart from RUN, then reload a single word
    restart();
    beat(8'h5A, 1'b0);
    beat(8'h6B, 1'b1);
    check_mem("pre_restart");
    restart();
    check_mem("after_restart");
    beat(8'hA5, 1'b1);
    check_mem("reload");

    // Restart and a beat in the same LOAD cycle: beat dropped
    restart();
    bus.ld_valid   = 1'b1;
    bus.ld_data    = 8'hFF;
    bus.ld_last    = 1'b1;
    bus.ld_restart = 1'b1;
    tick();
    bus.ld_valid   = 1'b0;
    bus.ld_last    = 1'b0;
    bus.ld_restart = 1'b0;
    check_mem("restart_drop");

    // Reset mid-load after 2 of 4 beats, then finish a fresh load
    beat(8'hC1, 1'b0);
    beat(8'hC2, 1'b0);
    sb_q.delete();
    n_reset      = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'hDD;
    tick();
    tick();
    n_reset      = 1'b0;
    bus.ld_valid = 1'b0;
    check_mem("mid_reset");
    beat(8'hC3, 1'b0);
    beat(8'hC4, 1'b1);
    check_mem("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
